// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared constants and saturating-counter helpers for the branch predictor
//
// Purpose : indexing-mode constants plus the counter reset-value and
//           saturating step functions used by the PHT and the perf counters.
// Ports   : none (package).
package bpu_pkg;

    localparam int MODE_LOCAL  = 0;
    localparam int MODE_GSHARE = 1;

    // Weakly-not-taken encoding: 0111...1 at the given width (01 for 2 bits).
    function automatic logic [31:0] ctrResetValue(input int bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    // One saturating step up or down at the given width.
    // A 32-bit width saturates at all-ones without overflowing the shift.
    function automatic logic [31:0] satStep(input logic [31:0] value,
                                            input logic        up,
                                            input int          bits);
        logic [31:0] maxVal;
        maxVal = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        if (up) begin
            return (value == maxVal) ? value : value + 32'd1;
        end
        return (value == 32'd0) ? value : value - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// rtl/sat_counter_table.sv - pattern history table of saturating counters
//
// Purpose : 2**INDEX_BITS saturating counters with one combinational read
//           port and one synchronous update port; synchronous active-high
//           reset puts every counter at weakly-not-taken.
// Ports   : clk, rst          clock and synchronous reset
//           readIndex         lookup index (combinational read)
//           readCounter       counter value at readIndex (pre-update value)
//           updateEn          apply a training step this edge
//           updateIndex       entry to train
//           updateTaken       1 = step up, 0 = step down
module sat_counter_table
    import bpu_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] readIndex,
    output logic [CTR_BITS-1:0]   readCounter,
    input  logic                  updateEn,
    input  logic [INDEX_BITS-1:0] updateIndex,
    input  logic                  updateTaken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] RESET_VALUE = CTR_BITS'(ctrResetValue(CTR_BITS));

    logic [CTR_BITS-1:0] counters [ENTRIES];
    logic [CTR_BITS-1:0] nextCounter;

    assign nextCounter = CTR_BITS'(satStep(32'(counters[updateIndex]), updateTaken, CTR_BITS));

    // No bypass: a read of the entry being trained this edge sees the old value.
    assign readCounter = counters[readIndex];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= RESET_VALUE;
            end
        end else if (updateEn) begin
            counters[updateIndex] <= nextCounter;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - two-level branch predictor (local or gshare indexing)
//
// Purpose : combinational fetch-stage prediction from pcF; non-speculative
//           retraining from the M-stage resolution bundle.
// Config  : define BPU_PERF_COUNTERS_EN to build the resolved-branch and
//           mispredict counters; otherwise both count ports read 0.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           pcF                           fetch PC
//           predict_takeF                 MSB of the selected PHT counter
//           pc_hashingF                   pcF[PC_HASH_BITS+1:2]
//           PHT_indexF                    PHT index used for this prediction
//           branchM                       M-stage conditional branch, qualifies training
//           actually_takenM               resolved direction
//           predict_resultM               1 = prediction was correct
//           pc_hashingM, PHT_indexM       lookup context carried down the pipe
//           branch_countM                 resolved branch count
//           mispredict_countM             mispredict count
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_HASH_BITS   = 3,
    parameter int PHT_INDEX_BITS = 7,
    parameter int CTR_BITS       = 2,
    parameter int MODE           = MODE_LOCAL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pcF,
    output logic                      predict_takeF,
    output logic [PC_HASH_BITS-1:0]   pc_hashingF,
    output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
    input  logic                      branchM,
    input  logic                      actually_takenM,
    input  logic                      predict_resultM,
    input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
    input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
    output logic [31:0]               branch_countM,
    output logic [31:0]               mispredict_countM
);

    localparam int BHT_ENTRIES = 1 << PC_HASH_BITS;

    logic [PHT_INDEX_BITS-1:0] lookupIndex;
    logic [CTR_BITS-1:0]       lookupCounter;

    assign pc_hashingF   = pcF[PC_HASH_BITS+1:2];
    assign PHT_indexF    = lookupIndex;
    assign predict_takeF = lookupCounter[CTR_BITS-1];

    // Histories shift only on resolved branches, so wrong-path fetches
    // never disturb them.
    generate
        if (MODE == MODE_GSHARE) begin : gGshare
            logic [PHT_INDEX_BITS-1:0] ghr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ghr <= '0;
                end else if (branchM) begin
                    ghr <= {ghr[PHT_INDEX_BITS-2:0], actually_takenM};
                end
            end

            assign lookupIndex = ghr ^ pcF[PHT_INDEX_BITS+1:2];
        end else begin : gLocal
            logic [PHT_INDEX_BITS-1:0] bht [BHT_ENTRIES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < BHT_ENTRIES; i++) begin
                        bht[i] <= '0;
                    end
                end else if (branchM) begin
                    bht[pc_hashingM] <= {bht[pc_hashingM][PHT_INDEX_BITS-2:0], actually_takenM};
                end
            end

            assign lookupIndex = bht[pc_hashingF];
        end
    endgenerate

    sat_counter_table #(
        .INDEX_BITS (PHT_INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) phtTable (
        .clk         (clk),
        .rst         (rst),
        .readIndex   (lookupIndex),
        .readCounter (lookupCounter),
        .updateEn    (branchM),
        .updateIndex (PHT_indexM),
        .updateTaken (actually_takenM)
    );

`ifdef BPU_PERF_COUNTERS_EN
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (branchM) begin
            branchCount <= satStep(branchCount, 1'b1, 32);
            if (!predict_resultM) begin
                mispredictCount <= satStep(mispredictCount, 1'b1, 32);
            end
        end
    end

    assign branch_countM     = branchCount;
    assign mispredict_countM = mispredictCount;
`else
    assign branch_countM     = 32'd0;
    assign mispredict_countM = 32'd0;
`endif

    // Bits not consumed in every configuration (upper PC bits, the hash
    // carried down in gshare mode, the result flag without counters).
    logic unusedSink;
    assign unusedSink = ^{pcF, predict_resultM, pc_hashingM, lookupCounter};

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit in local and gshare modes
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        branchM;
    logic        actually_takenM;
    logic        predict_resultM;
    logic [2:0]  pc_hashingM;
    logic [6:0]  PHT_indexM;

    logic        pred0, pred1;
    logic [2:0]  hash0, hash1;
    logic [6:0]  idx0, idx1;
    logic [31:0] brCnt0, mpCnt0, brCnt1, mpCnt1;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_HASH_BITS(3), .PHT_INDEX_BITS(7), .CTR_BITS(2), .MODE(0)) dutLocal (
        .clk(clk), .rst(rst), .pcF(pcF),
        .predict_takeF(pred0), .pc_hashingF(hash0), .PHT_indexF(idx0),
        .branchM(branchM), .actually_takenM(actually_takenM), .predict_resultM(predict_resultM),
        .pc_hashingM(pc_hashingM), .PHT_indexM(PHT_indexM),
        .branch_countM(brCnt0), .mispredict_countM(mpCnt0)
    );

    branch_predict_unit #(.PC_HASH_BITS(3), .PHT_INDEX_BITS(7), .CTR_BITS(2), .MODE(1)) dutGshare (
        .clk(clk), .rst(rst), .pcF(pcF),
        .predict_takeF(pred1), .pc_hashingF(hash1), .PHT_indexF(idx1),
        .branchM(branchM), .actually_takenM(actually_takenM), .predict_resultM(predict_resultM),
        .pc_hashingM(pc_hashingM), .PHT_indexM(PHT_indexM),
        .branch_countM(brCnt1), .mispredict_countM(mpCnt1)
    );

    typedef struct {
        logic        pred0;
        logic [2:0]  hash0;
        logic [6:0]  idx0;
        logic        pred1;
        logic [6:0]  idx1;
        logic [31:0] brCnt;
        logic [31:0] mpCnt;
    } expT;

    expT sbq[$];

    int assertCount = 0;
    int failCount   = 0;

    logic [1:0]  modelPht0 [128];
    logic [1:0]  modelPht1 [128];
    logic [6:0]  modelBht  [8];
    logic [6:0]  modelGhr;
    logic [31:0] modelBr, modelMp;

    logic        obsPred0, obsPred1;
    logic [6:0]  obsIdx0, obsIdx1;
    logic [31:0] obsBr, obsMp;

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [1:0] modelStep(input logic [1:0] v, input logic up);
        if (up) return (v == 2'b11) ? 2'b11 : v + 2'b01;
        return (v == 2'b00) ? 2'b00 : v - 2'b01;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 128; i++) begin
            modelPht0[i] = 2'b01;
            modelPht1[i] = 2'b01;
        end
        for (int i = 0; i < 8; i++) modelBht[i] = 7'd0;
        modelGhr = 7'd0;
        modelBr  = 32'd0;
        modelMp  = 32'd0;
    endtask

    // Drive one cycle: push the expected lookup, compare at the falling edge,
    // then apply the model update at the rising edge.
    task automatic runCycle(input logic r, input logic [31:0] pc, input logic br,
                            input logic tk, input logic res,
                            input logic [2:0] hm, input logic [6:0] im);
        expT e, got;
        logic [6:0] i0, i1;
        rst = r; pcF = pc; branchM = br; actually_takenM = tk;
        predict_resultM = res; pc_hashingM = hm; PHT_indexM = im;
        i0 = modelBht[pc[4:2]];
        i1 = modelGhr ^ pc[8:2];
        e.pred0 = modelPht0[i0][1];
        e.hash0 = pc[4:2];
        e.idx0  = i0;
        e.pred1 = modelPht1[i1][1];
        e.idx1  = i1;
`ifdef BPU_PERF_COUNTERS_EN
        e.brCnt = modelBr;
        e.mpCnt = modelMp;
`else
        e.brCnt = 32'd0;
        e.mpCnt = 32'd0;
`endif
        sbq.push_back(e);
        @(negedge clk);
        got = sbq.pop_front();
        checkValue("pred_local", {31'd0, pred0}, {31'd0, got.pred0});
        checkValue("hash_local", {29'd0, hash0}, {29'd0, got.hash0});
        checkValue("idx_local",  {25'd0, idx0},  {25'd0, got.idx0});
        checkValue("hash_gshare", {29'd0, hash1}, {29'd0, got.hash0});
        checkValue("pred_gshare", {31'd0, pred1}, {31'd0, got.pred1});
        checkValue("idx_gshare", {25'd0, idx1},  {25'd0, got.idx1});
        checkValue("branch_count", brCnt0, got.brCnt);
        checkValue("mispredict_count", mpCnt0, got.mpCnt);
        checkValue("branch_count_g", brCnt1, got.brCnt);
        obsPred0 = pred0; obsPred1 = pred1; obsIdx0 = idx0; obsIdx1 = idx1;
        obsBr = brCnt0; obsMp = mpCnt0;
        @(posedge clk);
        if (r) begin
            resetModel();
        end else if (br) begin
            modelPht0[im] = modelStep(modelPht0[im], tk);
            modelPht1[im] = modelStep(modelPht1[im], tk);
            modelBht[hm]  = {modelBht[hm][5:0], tk};
            modelGhr      = {modelGhr[5:0], tk};
            if (modelBr != 32'hFFFF_FFFF) modelBr = modelBr + 1;
            if (!res && modelMp != 32'hFFFF_FFFF) modelMp = modelMp + 1;
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        runCycle(1'b0, pc, 1'b0, 1'b1, 1'b0, 3'd0, 7'd0);
    endtask

    initial begin
        rst = 1'b1; pcF = 32'd0; branchM = 1'b0; actually_takenM = 1'b0;
        predict_resultM = 1'b1; pc_hashingM = 3'd0; PHT_indexM = 7'd0;
        @(posedge clk); #1;
        resetModel();

        // Reset state
        idle(32'h0000_0010);
        checkValue("reset_pred", {31'd0, obsPred0}, 32'd0);
        checkValue("reset_idx_local", {25'd0, obsIdx0}, 32'd0);
        checkValue("reset_idx_gshare", {25'd0, obsIdx1}, 32'd4);

        // Two taken updates to PHT[5] / BHT[4]
        repeat (2) runCycle(1'b0, 32'h10, 1'b1, 1'b1, 1'b1, 3'd4, 7'd5);
        idle(32'h0000_0010);
        checkValue("bht4_idx", {25'd0, obsIdx0}, 32'd3);
        runCycle(1'b0, 32'h10, 1'b1, 1'b1, 1'b1, 3'd4, 7'd5);
        // GHR = 0000111; pc bits 0000010 selects PHT[5], saturated at 11
        idle(32'h0000_0008);
        checkValue("gshare_idx5", {25'd0, obsIdx1}, 32'd5);
        checkValue("pht5_sat", {31'd0, obsPred1}, 32'd1);
        idle(32'h0000_0040);
        checkValue("gshare_xor", {25'd0, obsIdx1}, 32'h17);

        // Saturation low on PHT[9]
        runCycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 7'd0);
        repeat (4) runCycle(1'b0, 32'h24, 1'b1, 1'b0, 1'b1, 3'd1, 7'd9);

        // Collision: BHT[2]=3 then lookup PHT[3] while it is trained
        runCycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 7'd0);
        repeat (2) runCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd0);
        runCycle(1'b0, 32'h08, 1'b1, 1'b1, 1'b1, 3'd5, 7'd3);
        checkValue("collide_same", {31'd0, obsPred0}, 32'd0);
        idle(32'h0000_0008);
        checkValue("collide_next", {31'd0, obsPred0}, 32'd1);

        // Reset wins over a simultaneous update
        runCycle(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 3'd4, 7'd4);
        idle(32'h0000_0010);
        checkValue("rst_wins_idx", {25'd0, obsIdx0}, 32'd0);

        // Perf counters: 10 updates (3 mispredicted), 5 idle cycles
        for (int i = 0; i < 10; i++)
            runCycle(1'b0, 32'h100 + 4 * i, 1'b1, i[0], (i % 4) != 0, 3'(i), 7'(i * 3));
        repeat (5) idle(32'h0000_0020);
        idle(32'h0000_0020);
`ifdef BPU_PERF_COUNTERS_EN
        checkValue("perf_branches", obsBr, 32'd10);
        checkValue("perf_mispredicts", obsMp, 32'd3);
`else
        checkValue("perf_branches", obsBr, 32'd0);
        checkValue("perf_mispredicts", obsMp, 32'd0);
`endif
        runCycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 7'd0);
        idle(32'h0000_0020);
        checkValue("perf_clear_br", obsBr, 32'd0);
        checkValue("perf_clear_mp", obsMp, 32'd0);

        // Random traffic against the model, including occasional resets
        for (int i = 0; i < 400; i++) begin
            runCycle(($urandom % 50) == 0, $urandom, ($urandom % 3) != 0,
                     1'($urandom), 1'($urandom), 3'($urandom), 7'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
